// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared widths, stage modes and overflow helpers for the MAC pipeline
package dsp_pkg;

    localparam int DEF_A_WIDTH   = 18;
    localparam int DEF_B_WIDTH   = 18;
    localparam int DEF_ACC_WIDTH = 48;

    typedef enum logic {
        REG_BYPASS  = 1'b0,
        REG_ENABLED = 1'b1
    } reg_mode_e;

    typedef enum logic [1:0] {
        SAT_NONE = 2'd0,
        SAT_MAX  = 2'd1,
        SAT_MIN  = 2'd2
    } sat_kind_e;

    // top3 holds bits [W+1:W-1] of a sum computed two guard bits wider than
    // the accumulator; signed results fit only when those bits agree, unsigned
    // results fit only when both guard bits are clear.
    function automatic logic acc_overflow(input logic is_signed, input logic [2:0] top3);
        if (is_signed) begin
            return !((top3 == 3'b000) || (top3 == 3'b111));
        end
        return (top3[2:1] != 2'b00);
    endfunction

    // A negative out-of-range result clamps low (0 when unsigned), otherwise high.
    function automatic sat_kind_e sat_kind(input logic is_signed, input logic [2:0] top3);
        if (!acc_overflow(is_signed, top3)) begin
            return SAT_NONE;
        end
        return top3[2] ? SAT_MIN : SAT_MAX;
    endfunction

endpackage

// File: rtl/dsp_pipe_reg.sv
// rtl/dsp_pipe_reg.sv - optional data+valid pipeline register that collapses to a wire
module dsp_pipe_reg
    import dsp_pkg::*;
#(
    parameter int        WIDTH = 8,
    parameter reg_mode_e MODE  = REG_ENABLED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    input  logic             valid_d,
    output logic [WIDTH-1:0] q,
    output logic             valid_q
);

    generate
        if (MODE == REG_ENABLED) begin : g_reg
            // Data and its valid bit advance together on every enabled edge
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q       <= '0;
                    valid_q <= 1'b0;
                end else if (ce) begin
                    q       <= d;
                    valid_q <= valid_d;
                end
            end
        end else begin : g_wire
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, rst, ce};
            assign q           = d;
            assign valid_q     = valid_d;
        end
    endgenerate

endmodule

// File: rtl/dsp_mac_pipe.sv
// rtl/dsp_mac_pipe.sv - pipelined multiply-accumulate with wrap/saturate and sticky overflow
module dsp_mac_pipe
    import dsp_pkg::*;
#(
    parameter int A_WIDTH   = DEF_A_WIDTH,
    parameter int B_WIDTH   = DEF_B_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int REG_IN    = 1,
    parameter int REG_PIPE  = 1,
    parameter int REG_OUT   = 0,
    parameter int SIGNED    = 1,
    parameter int SAT       = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic [A_WIDTH-1:0]   a,
    input  logic [B_WIDTH-1:0]   b,
    input  logic                 valid_in,
    input  logic                 load,
    input  logic                 addsub,
    output logic [ACC_WIDTH-1:0] p,
    output logic                 valid_out,
    output logic                 ovf
);

    localparam int   PW        = A_WIDTH + B_WIDTH;
    localparam int   XW        = ACC_WIDTH + 2;
    localparam int   IW        = PW + 2;
    localparam logic IS_SIGNED = (SIGNED != 0);
    localparam logic DO_SAT    = (SAT != 0);

    logic [IW-1:0]        in_q;
    logic                 s1_valid, s1_load, s1_addsub;
    logic [A_WIDTH-1:0]   s1_a;
    logic [B_WIDTH-1:0]   s1_b;
    logic [PW-1:0]        a_ext, b_ext, prod;
    logic [PW+1:0]        pipe_q;
    logic                 s2_valid, s2_load, s2_addsub;
    logic [PW-1:0]        s2_prod;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d, acc_valid_q;
    logic [XW-1:0]        prod_x, base_x, sum_x;
    logic [2:0]           sum_top;

    dsp_pipe_reg #(
        .WIDTH (IW),
        .MODE  ((REG_IN != 0) ? REG_ENABLED : REG_BYPASS)
    ) u_in_reg (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .d       ({load, addsub, a, b}),
        .valid_d (valid_in),
        .q       (in_q),
        .valid_q (s1_valid)
    );

    assign {s1_load, s1_addsub, s1_a, s1_b} = in_q;

    // Both operands are extended to the full product width first, so a single
    // modular multiply yields the exact signed or unsigned product.
    assign a_ext = {{B_WIDTH{IS_SIGNED & s1_a[A_WIDTH-1]}}, s1_a};
    assign b_ext = {{A_WIDTH{IS_SIGNED & s1_b[B_WIDTH-1]}}, s1_b};
    assign prod  = a_ext * b_ext;

    dsp_pipe_reg #(
        .WIDTH (PW + 2),
        .MODE  ((REG_PIPE != 0) ? REG_ENABLED : REG_BYPASS)
    ) u_pipe_reg (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .d       ({s1_load, s1_addsub, prod}),
        .valid_d (s1_valid),
        .q       (pipe_q),
        .valid_q (s2_valid)
    );

    assign {s2_load, s2_addsub, s2_prod} = pipe_q;

    // Next accumulator value: load starts from zero and drops the old sticky flag
    always_comb begin
        prod_x  = {{(XW - PW){IS_SIGNED & s2_prod[PW-1]}}, s2_prod};
        base_x  = s2_load ? '0 : {{2{IS_SIGNED & acc_q[ACC_WIDTH-1]}}, acc_q};
        sum_x   = s2_addsub ? (base_x - prod_x) : (base_x + prod_x);
        sum_top = sum_x[XW-1:XW-3];
        acc_d   = sum_x[ACC_WIDTH-1:0];
        if (DO_SAT) begin
            case (sat_kind(IS_SIGNED, sum_top))
                SAT_MAX: acc_d = IS_SIGNED ? {1'b0, {(ACC_WIDTH-1){1'b1}}} : {ACC_WIDTH{1'b1}};
                SAT_MIN: acc_d = IS_SIGNED ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {ACC_WIDTH{1'b0}};
                default: acc_d = sum_x[ACC_WIDTH-1:0];
            endcase
        end
        ovf_d = (s2_load ? 1'b0 : ovf_q) | acc_overflow(IS_SIGNED, sum_top);
    end

    // Accumulator stage is always registered; only valid slots change acc and ovf
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            acc_valid_q <= 1'b0;
        end else if (ce) begin
            acc_valid_q <= s2_valid;
            if (s2_valid) begin
                acc_q <= acc_d;
                ovf_q <= ovf_d;
            end
        end
    end

    dsp_pipe_reg #(
        .WIDTH (ACC_WIDTH + 1),
        .MODE  ((REG_OUT != 0) ? REG_ENABLED : REG_BYPASS)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .d       ({ovf_q, acc_q}),
        .valid_d (acc_valid_q),
        .q       ({ovf, p}),
        .valid_q (valid_out)
    );

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// tb/tb_dsp_mac_pipe.sv - scoreboard bench driving four configurations of the MAC pipeline
module tb_dsp_mac_pipe;

    localparam int N = 4;

    typedef struct {
        logic [47:0] p;
        logic        ovf;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b0;
    logic [17:0] a = '0;
    logic [17:0] b = '0;
    logic        valid_in = 1'b0;
    logic        load = 1'b0;
    logic        addsub = 1'b0;

    logic [47:0] p0;
    logic [35:0] p1;
    logic [39:0] p2;
    logic [36:0] p3;
    logic        v0, v1, v2, v3;
    logic        o0, o1, o2, o3;

    int     cfg_w [N];
    bit     cfg_s [N];
    bit     cfg_t [N];
    int     cfg_l [N];
    longint m_acc [N];
    bit     m_ovf [N];
    exp_t   sb_q [N][$];

    int n_cmp = 0;
    int n_bad = 0;
    int ce_cnt = 0;
    bit last_ce = 1'b0;

    dsp_mac_pipe u0 (
        .clk(clk), .rst(rst), .ce(ce), .a(a), .b(b), .valid_in(valid_in),
        .load(load), .addsub(addsub), .p(p0), .valid_out(v0), .ovf(o0)
    );

    dsp_mac_pipe #(.ACC_WIDTH(36), .REG_IN(0), .REG_PIPE(0), .REG_OUT(0)) u1 (
        .clk(clk), .rst(rst), .ce(ce), .a(a), .b(b), .valid_in(valid_in),
        .load(load), .addsub(addsub), .p(p1), .valid_out(v1), .ovf(o1)
    );

    dsp_mac_pipe #(.ACC_WIDTH(40), .REG_IN(0), .REG_PIPE(1), .REG_OUT(1), .SAT(1)) u2 (
        .clk(clk), .rst(rst), .ce(ce), .a(a), .b(b), .valid_in(valid_in),
        .load(load), .addsub(addsub), .p(p2), .valid_out(v2), .ovf(o2)
    );

    dsp_mac_pipe #(.ACC_WIDTH(37), .REG_IN(1), .REG_PIPE(0), .REG_OUT(1), .SIGNED(0), .SAT(1)) u3 (
        .clk(clk), .rst(rst), .ce(ce), .a(a), .b(b), .valid_in(valid_in),
        .load(load), .addsub(addsub), .p(p3), .valid_out(v3), .ovf(o3)
    );

    always #5 clk = ~clk;

    // Count clock-enabled edges; latency is measured in these
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            last_ce <= 1'b0;
        end else begin
            last_ce <= ce;
            if (ce) ce_cnt <= ce_cnt + 1;
        end
    end

    task automatic cmp(input string nm, input longint got, input longint req);
        n_cmp++;
        if (got != req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, got, req);
        end
    endtask

    task automatic check_out(input int i, input logic [47:0] pv, input logic ov);
        exp_t e;
        if (sb_q[i].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_valid_dut%0d: got p=%0h, required no output", i, pv);
            return;
        end
        e = sb_q[i].pop_front();
        cmp($sformatf("p_dut%0d", i), longint'(pv), longint'(e.p));
        cmp($sformatf("ovf_dut%0d", i), longint'(ov), longint'(e.ovf));
        cmp($sformatf("latency_dut%0d", i), longint'(ce_cnt), longint'(e.due));
    endtask

    // Monitor: a new output slot exists only after a clock-enabled edge
    always @(negedge clk) begin
        if (!rst && last_ce) begin
            if (v0) check_out(0, p0, o0);
            if (v1) check_out(1, 48'(p1), o1);
            if (v2) check_out(2, 48'(p2), o2);
            if (v3) check_out(3, 48'(p3), o3);
        end
    end

    // Reference model: exact integer arithmetic, then range check and clamp/wrap
    task automatic issue(input logic [17:0] av, input logic [17:0] bv, input logic ld, input logic sub);
        longint pa, pb, prod, res, lo, hi, span, r;
        exp_t   e;
        for (int i = 0; i < N; i++) begin
            if (cfg_s[i]) begin
                pa = $signed(av);
                pb = $signed(bv);
            end else begin
                pa = longint'(av);
                pb = longint'(bv);
            end
            prod = pa * pb;
            if (ld) m_ovf[i] = 1'b0;
            res  = (ld ? 64'sd0 : m_acc[i]) + (sub ? -prod : prod);
            span = longint'(1) << cfg_w[i];
            lo   = cfg_s[i] ? -(span / 2) : 64'sd0;
            hi   = cfg_s[i] ? (span / 2 - 1) : (span - 1);
            if (res < lo || res > hi) begin
                m_ovf[i] = 1'b1;
                if (cfg_t[i]) begin
                    res = (res < lo) ? lo : hi;
                end else begin
                    r = (res - lo) % span;
                    if (r < 0) r = r + span;
                    res = r + lo;
                end
            end
            m_acc[i] = res;
            e.p      = 48'(res & (span - 1));
            e.ovf    = m_ovf[i];
            e.due    = ce_cnt + cfg_l[i];
            sb_q[i].push_back(e);
        end
    endtask

    task automatic step(input logic v, input logic [17:0] av, input logic [17:0] bv,
                        input logic ld, input logic sub, input logic c);
        @(posedge clk);
        #2;
        valid_in = v;
        a        = av;
        b        = bv;
        load     = ld;
        addsub   = sub;
        ce       = c;
        if (v && c) issue(av, bv, ld, sub);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 18'h0, 18'h0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic reset_model();
        for (int i = 0; i < N; i++) begin
            m_acc[i] = 0;
            m_ovf[i] = 1'b0;
            sb_q[i].delete();
        end
    endtask

    task automatic check_cleared(input string tag);
        cmp({tag, "_p0"}, longint'(p0), 0);  cmp({tag, "_o0"}, longint'(o0), 0);  cmp({tag, "_v0"}, longint'(v0), 0);
        cmp({tag, "_p1"}, longint'(p1), 0);  cmp({tag, "_o1"}, longint'(o1), 0);  cmp({tag, "_v1"}, longint'(v1), 0);
        cmp({tag, "_p2"}, longint'(p2), 0);  cmp({tag, "_o2"}, longint'(o2), 0);  cmp({tag, "_v2"}, longint'(v2), 0);
        cmp({tag, "_p3"}, longint'(p3), 0);  cmp({tag, "_o3"}, longint'(o3), 0);  cmp({tag, "_v3"}, longint'(v3), 0);
    endtask

    initial begin
        cfg_w = '{48, 36, 40, 37};
        cfg_s = '{1, 1, 1, 0};
        cfg_t = '{0, 0, 1, 1};
        cfg_l = '{3, 1, 3, 3};
        reset_model();

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        check_cleared("reset");

        // Load 3*4, then accumulate -2*5
        step(1'b1, 18'd3, 18'd4, 1'b1, 1'b0, 1'b1);
        step(1'b1, 18'h3FFFE, 18'd5, 1'b0, 1'b0, 1'b1);
        idle(5);

        // Single load 7*7
        step(1'b1, 18'd7, 18'd7, 1'b1, 1'b0, 1'b1);
        idle(5);

        // Large positive products until narrow accumulators wrap, then reload
        step(1'b1, 18'h1FFFF, 18'h1FFFF, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b1, 18'h1FFFF, 18'h1FFFF, 1'b0, 1'b0, 1'b1);
        step(1'b1, 18'd2, 18'd3, 1'b1, 1'b0, 1'b1);

        // Drive toward the negative limit until saturation holds, then reload
        step(1'b1, 18'h20000, 18'h1FFFF, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 36; k++) step(1'b1, 18'h20000, 18'h1FFFF, 1'b0, 1'b0, 1'b1);
        step(1'b1, 18'd1, 18'd1, 1'b1, 1'b0, 1'b1);

        // Negated loads, including the most negative operand pair
        step(1'b1, 18'h20000, 18'h20000, 1'b1, 1'b1, 1'b1);
        step(1'b1, 18'd9, 18'd11, 1'b1, 1'b1, 1'b1);
        idle(5);

        // Four samples with clock enable low for three cycles in the middle
        step(1'b1, 18'd10, 18'd10, 1'b1, 1'b0, 1'b1);
        step(1'b1, 18'd20, 18'd3, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b1, 18'h155, 18'h2AA, 1'b1, 1'b1, 1'b0);
        step(1'b1, 18'd5, 18'd6, 1'b0, 1'b1, 1'b1);
        step(1'b1, 18'd1, 18'd100, 1'b0, 1'b0, 1'b1);
        idle(6);

        // Reset with two samples in flight
        step(1'b1, 18'd4, 18'd4, 1'b1, 1'b0, 1'b1);
        step(1'b1, 18'd8, 18'd8, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #3;
        valid_in = 1'b0;
        rst      = 1'b1;
        reset_model();
        #1 check_cleared("midreset");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        idle(8);

        // Randomized traffic with random clock-enable gaps
        for (int k = 0; k < 400; k++) begin
            logic [17:0] ra, rb;
            ra = ($urandom_range(0, 7) == 0) ? 18'h20000 : 18'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 18'h1FFFF : 18'($urandom);
            step(($urandom_range(0, 9) < 7), ra, rb, ($urandom_range(0, 9) < 2),
                 1'($urandom), ($urandom_range(0, 9) < 8));
        end
        idle(8);

        for (int i = 0; i < N; i++) cmp($sformatf("drained_dut%0d", i), longint'(sb_q[i].size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
